// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into little-endian words, writes them to
// instruction memory, and holds the core in reset until a terminator word.
module uart_imem_loader #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              write_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic              timeout_err
);

  localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

  state_t        state;
  logic [1:0]    bi;
  logic [31:0]   wbuf;
  logic [31:0]   pend_word;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic [31:0]   full_word;

  always_comb begin
    accept    = rx_valid && (state != DONE);
    full_word = {rx_data, wbuf[23:0]};
  end

  // The completed word is parked in pend_word so bytes of the next word can
  // land in wbuf while the write is still pending.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= LOAD;
      bi          <= 2'd0;
      wbuf        <= 32'd0;
      pend_word   <= 32'd0;
      tcnt        <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      cpu_rst     <= 1'b1;
      write_done  <= 1'b0;
      overflow    <= 1'b0;
      word_count  <= '0;
      timeout_err <= 1'b0;
    end else if (rx_break) begin
      state      <= LOAD;
      bi         <= 2'd0;
      tcnt       <= '0;
      imem_we    <= 1'b0;
      cpu_rst    <= 1'b1;
      write_done <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we && word_count != CAP)
        word_count <= word_count + 1'b1;

      // A byte arriving in the expiry cycle wins over the timeout.
      if (accept) begin
        wbuf[{bi, 3'b000} +: 8] <= rx_data;
        bi   <= bi + 2'd1;
        tcnt <= '0;
      end else if (bi == 2'd0) begin
        tcnt <= '0;
      end else if (state == LOAD) begin
        if (tcnt == TLAST) begin
          bi          <= 2'd0;
          timeout_err <= 1'b1;
          tcnt        <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end

      case (state)
        LOAD: begin
          if (accept && bi == 2'd3) begin
            if (full_word == END_WORD) begin
              state <= DONE;
            end else if (word_count == CAP) begin
              overflow <= 1'b1;
              state    <= DONE;
            end else begin
              pend_word <= full_word;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          imem_we    <= 1'b1;
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= pend_word;
          state      <= LOAD;
        end
        DONE: begin
          write_done <= 1'b1;
          cpu_rst    <= 1'b0;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: expected writes are queued as words
// complete, and a negedge monitor matches every imem_we pulse against them.
module tb_uart_imem_loader;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_break = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              write_done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic              timeout_err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_edge = 0;
  logic prev_we = 1'b0;

  uart_imem_loader #(
    .ADDR_W(ADDR_W),
    .END_WORD(32'hFFFF_FFFF),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_break(rx_break),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .write_done(write_done),
    .overflow(overflow),
    .word_count(word_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_we) begin
      checkOutput("we_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: addr %h data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("write_addr", {30'd0, imem_addr}, {30'd0, e.addr});
        checkOutput("write_data", imem_wdata, e.data);
        checkOutput("write_cycle", cyc, e.cyc);
      end
    end
    prev_we <= imem_we;
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    last_edge = cyc;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit wr, input logic [ADDR_W-1:0] addr);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8]);
      if (i == 3 && wr) exp_q.push_back('{addr: addr, data: w, cyc: last_edge + 1});
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    checkOutput({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, write_done}, 32'd0);
    checkOutput({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    checkOutput({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
    checkOutput({tag, "_count"}, {29'd0, word_count}, 32'd0);
    checkOutput({tag, "_addr"}, {30'd0, imem_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  task automatic waitAfterTerminator();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clk);
    applyReset();
    @(negedge clk);
    checkResetValues("reset");

    // Three program words then the terminator.
    sendWord(32'hFC01_0113, 1'b1, 2'd0);
    sendWord(32'h0211_2E23, 1'b1, 2'd1);
    sendWord(32'h0000_0013, 1'b1, 2'd2);
    @(negedge clk);
    checkOutput("load_cpu_rst_held", {31'd0, cpu_rst}, 32'd1);
    checkOutput("load_count_pre", {29'd0, word_count}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'hFF);
      if (i < 3) @(posedge clk);
    end
    waitAfterTerminator();
    checkOutput("load_done", {31'd0, write_done}, 32'd1);
    checkOutput("load_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("load_count", {29'd0, word_count}, 32'd3);
    repeat (3) @(posedge clk);
    checkOutput("load_pending", exp_q.size(), 32'd0);

    // Partial word discarded by the timeout.
    applyReset();
    applyStimulus(8'hAA);
    @(posedge clk);
    applyStimulus(8'hBB);
    repeat (150) @(posedge clk);
    @(negedge clk);
    checkOutput("tmo_err", {31'd0, timeout_err}, 32'd1);
    sendWord(32'h4433_2211, 1'b1, 2'd0);
    @(negedge clk);
    checkOutput("tmo_count", {29'd0, word_count}, 32'd1);
    checkOutput("tmo_pending", exp_q.size(), 32'd0);
    @(negedge clk);
    rx_break = 1'b1;
    @(posedge clk);
    #1;
    rx_break = 1'b0;
    @(negedge clk);
    checkOutput("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    checkOutput("tmo_break_count", {29'd0, word_count}, 32'd0);

    // Memory full: fifth word ends the load with overflow.
    applyReset();
    sendWord(32'hA000_0001, 1'b1, 2'd0);
    sendWord(32'hA000_0002, 1'b1, 2'd1);
    sendWord(32'hA000_0003, 1'b1, 2'd2);
    sendWord(32'hA000_0004, 1'b1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h55);
      if (i < 3) @(posedge clk);
    end
    waitAfterTerminator();
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_done", {31'd0, write_done}, 32'd1);
    checkOutput("ovf_count", {29'd0, word_count}, 32'd4);
    checkOutput("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    sendWord(32'h1234_5678, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("done_ignores_rx", {29'd0, word_count}, 32'd4);
    checkOutput("ovf_pending", exp_q.size(), 32'd0);

    // Break with a simultaneous byte restarts loading from address 0.
    applyReset();
    sendWord(32'h1111_1111, 1'b1, 2'd0);
    sendWord(32'h2222_2222, 1'b1, 2'd1);
    applyStimulus(8'h77);
    @(negedge clk);
    rx_break = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(posedge clk);
    #1;
    rx_break = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    checkOutput("brk_count", {29'd0, word_count}, 32'd0);
    checkOutput("brk_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    sendWord(32'h0000_006F, 1'b1, 2'd0);
    @(negedge clk);
    checkOutput("brk_cpu_rst_held", {31'd0, cpu_rst}, 32'd1);
    checkOutput("brk_done_low", {31'd0, write_done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'hFF);
      if (i < 3) @(posedge clk);
    end
    waitAfterTerminator();
    checkOutput("brk_done", {31'd0, write_done}, 32'd1);
    checkOutput("brk_final_count", {29'd0, word_count}, 32'd1);
    checkOutput("brk_pending", exp_q.size(), 32'd0);

    // Reset coinciding with the fourth byte suppresses the write.
    applyReset();
    applyStimulus(8'h01);
    @(posedge clk);
    applyStimulus(8'h02);
    @(posedge clk);
    applyStimulus(8'h03);
    @(posedge clk);
    @(negedge clk);
    resetn   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("rst_mid");
    sendWord(32'hCAFE_0042, 1'b1, 2'd0);
    @(negedge clk);
    checkOutput("rst_mid_count", {29'd0, word_count}, 32'd1);
    checkOutput("rst_mid_pending", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
